hamming_decoder: RTL and testbench
==================================

# hamming_decoder

Memory-mapped SECDED decoder engine; the receive-side counterpart of the program-1 Hamming(16,11) encoder. On a Start handshake it reads NUM_WORDS 16-bit codewords from data memory, corrects single-bit errors, flags double-bit errors, and writes 11-bit data plus a 2-bit status back to memory. It then raises Ack. It sits beside the core on the data-memory port and uses the same Start/Ack protocol as TopLevel.

## Interface
- SRC_BASE, 30: byte address of the first codeword LSW; its MSW is at SRC_BASE+1.
- DST_BASE, 0: byte address of the first decoded LSW; its MSW is at DST_BASE+1.
- NUM_WORDS, 15: codewords per run, range 1..15.
- AW, 8: memory address width.

- Clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; a run launches on the Start high-to-low transition.
- Ack  out  1  done flag.
- MemAddr  out  AW  memory byte address.
- MemRdData  in  8  read data; valid the cycle after MemAddr is presented (registered read).
- MemWrEn  out  1  write strobe, one cycle per byte.
- MemWrData  out  8  write data.
- SingleCnt  out  4  count of corrected words in the last run.
- DoubleCnt  out  4  count of double-error words in the last run.

## Operation
- Codeword bit map, positions 15..0:
  - 15..9 = b11..b5
  - 8 = p8
  - 7..5 = b4..b2
  - 4 = p4
  - 3 = b1
  - 2 = p2
  - 1 = p1
  - 0 = p0, overall even parity
- Syndrome s[k] = XOR of all bits whose position index has bit k set, k = 0..3. P = XOR of all 16 bits.
- Decode rules:
  - s==0, P==0: no error; F = 00.
  - P==1: single error at position s (s==0 means p0); flip that bit; F = 01.
  - s!=0, P==0: double error; no correction; data is taken raw; F = 10.
- Output format:
  - LSW = b8..b1
  - MSW = {F1, F0, 3'b000, b11, b10, b9}
- FSM states: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE.
  - IDLE: wait for Start high-to-low (previous-cycle Start register is 1, current is 0). On launch: index i = 0, counters cleared, go to RD_LO.
  - RD_LO: MemAddr = SRC_BASE+2i.
  - RD_HI: MemAddr = SRC_BASE+2i+1; capture MemRdData as LSW.
  - CAP: capture MemRdData as MSW.
  - WR_LO: MemAddr = DST_BASE+2i, MemWrEn = 1, MemWrData = decoded LSW. Increment SingleCnt or DoubleCnt if applicable.
  - WR_HI: MemAddr = DST_BASE+2i+1, MemWrEn = 1, MemWrData = decoded MSW. If i == NUM_WORDS-1 go to DONE; else i++ and go to RD_LO.
  - DONE: Ack = 1. Stay until Start is sampled high, then go to IDLE (Ack = 0 next cycle).
- Decode is combinational from the captured LSW/MSW registers.
- MemWrEn is high only in WR_LO and WR_HI.
- Start activity between launch and DONE is ignored. The falling-edge detector is re-armed only in IDLE.

## Timing
- Reset values (async, Reset = 0): state IDLE, Ack 0, MemWrEn 0, MemAddr 0, MemWrData 0, SingleCnt 0, DoubleCnt 0, i 0, Start history register 1 (no launch without a real high-to-low edge after reset).
- Per word: 5 cycles. Run: launch edge + 5·NUM_WORDS cycles to entering DONE; 76 cycles for NUM_WORDS = 15.
- Ack rises on the cycle after the last WR_HI. The final MSW write is complete before Ack is seen.
- Reset mid-run: immediate return to IDLE with MemWrEn low. Bytes already written stay; no further writes.
- Start held high in DONE for 1 cycle is enough to return to IDLE. Start held low forever in DONE keeps Ack high.
- The src and dst regions do not overlap at the defaults. With overlap, reads of index i happen before writes of index i (defined behaviour).

## Test plan
- Clean word: codeword 01110010_10110001 at [31]/[30] → [1]/[0] = 00000011/10011010; SingleCnt 0, DoubleCnt 0.
- Single error in a data bit (bit 5 flipped): LSW 10010001 → output 01000011/10011010; SingleCnt 1.
- Single error in p0: LSW 10110000 → 01000011/10011010. All-ones codeword 0xFFFF → 00000111/11111111 with F = 00. All-zero codeword → 00000000/00000000.
- Double error (bits 5 and 3 flipped): LSW 10011001 → 10000011/10011001; DoubleCnt 1; no correction applied.
- Full 15-word run of mixed patterns:
  - Ack rises exactly 76 cycles after the Start falling edge.
  - Exactly 30 write strobes, to addresses 0..29 in order.
  - Addresses 30..59 are untouched.
  - Ack drops one cycle after Start rises.
- Reset asserted at cycle 20 of a run: Ack 0 and no writes afterward. A new Start pulse then performs a complete, correct run.

Source files
------------

// File: rtl/hamming_decoder_if.sv
// Memory-port and Start/Ack bundle between the SECDED decoder engine and its host.
interface hamming_decoder_if #(
  parameter int AW = 8
);
  logic          start;
  logic          ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [3:0]    single_cnt;
  logic [3:0]    double_cnt;

  modport slave (
    input  start, mem_rd_data,
    output ack, mem_addr, mem_wr_en, mem_wr_data, single_cnt, double_cnt
  );

  modport master (
    output start, mem_rd_data,
    input  ack, mem_addr, mem_wr_en, mem_wr_data, single_cnt, double_cnt
  );
endinterface

// File: rtl/hamming_decoder.sv
// SECDED Hamming(16,11) decoder engine: reads codeword byte pairs from memory,
// corrects single errors, flags double errors, writes data plus status back.
//
// state | meaning
// IDLE  | wait for start falling edge
// RD_LO | present codeword LSW address
// RD_HI | present MSW address, capture LSW
// CAP   | capture MSW
// WR_LO | write decoded LSW, bump error counters
// WR_HI | write decoded MSW, advance word index
// DONE  | hold ack until start is seen high
module hamming_decoder #(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15,
  parameter int AW        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  hamming_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE
  } state_t;

  localparam logic [AW-1:0] SRC  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST  = AW'(DST_BASE);
  localparam logic [3:0]    LAST = 4'(NUM_WORDS - 1);

  state_t        state, state_nxt;
  logic [3:0]    idx;
  logic [7:0]    lsw_q, msw_q;
  logic [3:0]    single_q, double_q;
  logic          start_q;
  logic          launch;
  logic [AW-1:0] word_off;

  logic [15:0]   cw, fixed;
  logic [3:0]    syn;
  logic          par;
  logic [1:0]    flag;
  logic [7:0]    dec_lo, dec_hi;
  logic          unused_parity_bits;

  assign launch   = (state == IDLE) && start_q && !bus.start;
  assign word_off = AW'({idx, 1'b0});

  // Syndrome masks select the positions whose index has bit k set.
  always_comb begin
    cw     = {msw_q, lsw_q};
    syn[0] = ^(cw & 16'hAAAA);
    syn[1] = ^(cw & 16'hCCCC);
    syn[2] = ^(cw & 16'hF0F0);
    syn[3] = ^(cw & 16'hFF00);
    par    = ^cw;
    fixed  = par ? (cw ^ (16'd1 << syn)) : cw;
    if (par)
      flag = 2'b01;
    else if (syn != 4'd0)
      flag = 2'b10;
    else
      flag = 2'b00;
    dec_lo = {fixed[12:9], fixed[7:5], fixed[3]};
    dec_hi = {flag, 3'b000, fixed[15:13]};
  end

  assign unused_parity_bits = ^{fixed[8], fixed[4], fixed[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RD_LO;
      RD_LO:   state_nxt = RD_HI;
      RD_HI:   state_nxt = CAP;
      CAP:     state_nxt = WR_LO;
      WR_LO:   state_nxt = WR_HI;
      WR_HI:   state_nxt = (idx == LAST) ? DONE : RD_LO;
      DONE:    if (bus.start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ack         = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 8'h00;
    case (state)
      RD_LO: bus.mem_addr = SRC + word_off;
      RD_HI: bus.mem_addr = SRC + word_off + AW'(1);
      WR_LO: begin
        bus.mem_addr    = DST + word_off;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = dec_lo;
      end
      WR_HI: begin
        bus.mem_addr    = DST + word_off + AW'(1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = dec_hi;
      end
      DONE:    bus.ack = 1'b1;
      default: ;
    endcase
  end

  // Start history only tracks the pin while idle, so activity during a run
  // cannot arm a launch for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 4'd0;
      lsw_q    <= 8'h00;
      msw_q    <= 8'h00;
      single_q <= 4'd0;
      double_q <= 4'd0;
      start_q  <= 1'b1;
    end else begin
      if (state == IDLE)
        start_q <= bus.start;
      case (state)
        IDLE: if (launch) begin
          idx      <= 4'd0;
          single_q <= 4'd0;
          double_q <= 4'd0;
        end
        RD_HI: lsw_q <= bus.mem_rd_data;
        CAP:   msw_q <= bus.mem_rd_data;
        WR_LO: begin
          if (flag == 2'b01) single_q <= single_q + 4'd1;
          if (flag == 2'b10) double_q <= double_q + 4'd1;
        end
        WR_HI: if (idx != LAST) idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

  assign bus.single_cnt = single_q;
  assign bus.double_cnt = double_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: byte memory model, table-driven and randomized
// codeword runs, Start/Ack timing and mid-run reset sequences.
module tb_hamming_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hamming_decoder_if #(.AW(8)) bus ();

  hamming_decoder #(
    .SRC_BASE(30), .DST_BASE(0), .NUM_WORDS(15), .AW(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [0:255];
  logic [7:0] wr_log [$];

  always @(posedge clk) begin
    bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wr_data;
      wr_log.push_back(bus.mem_addr);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    else
      n_pass++;
  endtask

  // Reference model: syndrome as XOR of the indices of set bits, data bits
  // are the non-power-of-two positions in ascending order.
  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int n;
    d = '0;
    n = 0;
    for (int j = 1; j < 16; j++)
      if ((j & (j - 1)) != 0) begin
        d[n] = c[j];
        n++;
      end
    return d;
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int n, s;
    c = '0;
    n = 0;
    s = 0;
    for (int j = 1; j < 16; j++)
      if ((j & (j - 1)) != 0) begin
        c[j] = d[n];
        n++;
      end
    for (int j = 0; j < 16; j++) if (c[j]) s = s ^ j;
    for (int k = 0; k < 4; k++) c[1 << k] = s[k];
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [15:0] decode_ref(input logic [15:0] c_in);
    logic [15:0] c;
    logic [10:0] d;
    logic [1:0]  f;
    int s;
    c = c_in;
    s = 0;
    for (int j = 0; j < 16; j++) if (c[j]) s = s ^ j;
    if (($countones(c) % 2) == 1) begin
      c[s] = ~c[s];
      f = 2'b01;
    end else if (s != 0) begin
      f = 2'b10;
    end else begin
      f = 2'b00;
    end
    d = extract(c);
    return {f, 3'b000, d[10:8], d[7:0]};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] c;
    int p1, p2, nerr;
    c = encode(11'($urandom_range(0, 2047)));
    nerr = $urandom_range(0, 2);
    p1 = $urandom_range(0, 15);
    if (nerr >= 1) c[p1] = ~c[p1];
    if (nerr == 2) begin
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      c[p2] = ~c[p2];
    end
    return c;
  endfunction

  typedef struct {
    logic [15:0] cw;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t vecs [15];

  task automatic load_vecs();
    for (int k = 0; k < 15; k++) begin
      mem[30 + 2*k] = vecs[k].cw[7:0];
      mem[31 + 2*k] = vecs[k].cw[15:8];
    end
    for (int a = 0; a < 30; a++) mem[a] = 8'hEE;
    wr_log.delete();
  endtask

  task automatic run(input bit toggle, input string tag);
    int cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle && cyc == 10) bus.start = 1'b1;
      if (toggle && cyc == 12) bus.start = 1'b0;
      if (bus.ack) break;
    end
    check({tag, "_ack_latency"}, cyc, 76);
  endtask

  task automatic check_results(input string tag);
    int es, ed;
    es = 0;
    ed = 0;
    for (int k = 0; k < 15; k++) begin
      check($sformatf("%s_lo%0d", tag, k), mem[2*k], vecs[k].lo);
      check($sformatf("%s_hi%0d", tag, k), mem[2*k+1], vecs[k].hi);
      if (vecs[k].hi[7:6] == 2'b01) es++;
      if (vecs[k].hi[7:6] == 2'b10) ed++;
    end
    check({tag, "_wr_count"}, wr_log.size(), 30);
    for (int j = 0; j < 30 && j < wr_log.size(); j++)
      check($sformatf("%s_wr_addr%0d", tag, j), wr_log[j], j);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("%s_src_keep%0d", tag, k),
            {mem[31 + 2*k], mem[30 + 2*k]}, vecs[k].cw);
    end
    check({tag, "_single_cnt"}, bus.single_cnt, es);
    check({tag, "_double_cnt"}, bus.double_cnt, ed);
  endtask

  task automatic leave_done(input string tag);
    bus.start = 1'b1;
    check({tag, "_ack_before_edge"}, bus.ack, 1);
    @(posedge clk); #1;
    check({tag, "_ack_drop"}, bus.ack, 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 15; k++) begin
      vecs[k].cw = rand_word();
      {vecs[k].hi, vecs[k].lo} = decode_ref(vecs[k].cw);
    end
  endtask

  initial begin
    vecs[0] = '{16'h72B1, 8'b10011010, 8'b00000011};
    vecs[1] = '{16'h7291, 8'b10011010, 8'b01000011};
    vecs[2] = '{16'h72B0, 8'b10011010, 8'b01000011};
    vecs[3] = '{16'hFFFF, 8'b11111111, 8'b00000111};
    vecs[4] = '{16'h0000, 8'b00000000, 8'b00000000};
    vecs[5] = '{16'h7299, 8'b10011001, 8'b10000011};
    for (int k = 6; k < 15; k++) begin
      vecs[k].cw = rand_word();
      {vecs[k].hi, vecs[k].lo} = decode_ref(vecs[k].cw);
    end

    rst_n = 1'b0;
    bus.start = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.ack, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wr_data", bus.mem_wr_data, 0);
    check("rst_single", bus.single_cnt, 0);
    check("rst_double", bus.double_cnt, 0);
    rst_n = 1'b1;
    load_vecs();
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_launch_ack", bus.ack, 0);
    check("idle_no_launch_wr", wr_log.size(), 0);

    // Run 1: directed table plus model-checked random words.
    run(1'b0, "tbl");
    check_results("tbl");
    repeat (10) @(posedge clk);
    #1;
    check("tbl_ack_hold_low_start", bus.ack, 1);
    leave_done("tbl");

    // Run 2: random words, Start wiggled mid-run.
    fill_random();
    load_vecs();
    run(1'b1, "rnd");
    check_results("rnd");
    leave_done("rnd");

    // Run 3: reset after word 3 completes, then a fresh full run.
    fill_random();
    load_vecs();
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (21) @(posedge clk);
    #1 rst_n = 1'b0;
    bus.start = 1'b1;
    #1;
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_wr_en", bus.mem_wr_en, 0);
    check("mid_rst_written", wr_log.size(), 8);
    wr_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_writes", wr_log.size(), 0);
    check("mid_rst_ack_idle", bus.ack, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mid_rst_kept_lo%0d", k), mem[2*k], vecs[k].lo);
      check($sformatf("mid_rst_kept_hi%0d", k), mem[2*k+1], vecs[k].hi);
    end
    check("mid_rst_not_written", mem[8], 8'hEE);

    fill_random();
    load_vecs();
    run(1'b0, "post");
    check_results("post");
    leave_done("post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
